// File: rtl/p4_seq_pkg.sv
// ----------------------------------------------------------------------------
// p4_seq_pkg
//
// Purpose:
//     Shared definitions for the P4 wide-add sequencer: the sequencer state
//     encoding and a helper that sizes the word-index counter.
//
// Contents:
//     seq_state_e  - IDLE (waiting for operands), RUN (one word per cycle
//                    through the P4 adder), DONE (result held for downstream)
//     idx_width()  - bit width of a counter addressing n words, never below 1
// ----------------------------------------------------------------------------
package p4_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // A single-word operand still needs a 1-bit index so the counter exists.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/p4_wide_add_seq.sv
// ----------------------------------------------------------------------------
// p4_wide_add_seq
//
// Purpose:
//     Adds two NWORDS*DWIDTH-bit operands by feeding an external DWIDTH-bit
//     combinational P4 adder one word per cycle, least significant word first,
//     and chaining each word's carry-out into the next word's carry-in.
//
// Ports:
//     clk, rst              - rising-edge clock, synchronous active-high reset
//     in_valid / in_ready   - upstream operand handshake
//     in_a, in_b, in_cin    - wide operands (word 0 is the LSW) and carry-in
//     p4_a, p4_b, p4_cin    - word operands driven to the P4 adder (0 off RUN)
//     p4_s, p4_cout         - combinational sum / carry back from the P4 adder
//     out_valid / out_ready - downstream result handshake
//     out_sum, out_cout     - assembled wide sum and final carry-out
//     out_ovf               - signed two's-complement overflow of the wide add
//     busy                  - high while words are being streamed (RUN)
//     op_count              - number of results handed off, wraps at 2^CNTW
// ----------------------------------------------------------------------------
module p4_wide_add_seq
    import p4_seq_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int NWORDS = 4,
    parameter int CNTW   = 16
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NWORDS*DWIDTH-1:0] in_a,
    input  logic [NWORDS*DWIDTH-1:0] in_b,
    input  logic                     in_cin,

    output logic [DWIDTH-1:0]        p4_a,
    output logic [DWIDTH-1:0]        p4_b,
    output logic                     p4_cin,
    input  logic [DWIDTH-1:0]        p4_s,
    input  logic                     p4_cout,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NWORDS*DWIDTH-1:0] out_sum,
    output logic                     out_cout,
    output logic                     out_ovf,

    output logic                     busy,
    output logic [CNTW-1:0]          op_count
);

    localparam int              IW       = idx_width(NWORDS);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NWORDS - 1);

    seq_state_e r_state;
    seq_state_e w_nextState;

    // Operands and result are held as word arrays so the word mux and the
    // per-word write enable are plain array indexing by r_idx.
    logic [NWORDS-1:0][DWIDTH-1:0] r_aReg;
    logic [NWORDS-1:0][DWIDTH-1:0] r_bReg;
    logic [NWORDS-1:0][DWIDTH-1:0] r_sumReg;
    logic                          r_cinReg;
    logic                          r_carryReg;
    logic [IW-1:0]                 r_idx;
    logic [CNTW-1:0]               r_opCount;

    logic w_accept;
    logic w_handoff;
    logic w_lastWord;

    assign w_lastWord = (r_idx == LAST_IDX);
    assign op_count   = r_opCount;

    // State register. Reset from any state returns to IDLE, which abandons
    // an operation in flight without emitting a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and output decode. Every output defaults to 0 so the P4
    // operand bus is quiet outside RUN and the result bus is quiet outside
    // DONE. Accept only happens in IDLE, so a cycle that hands off a result
    // can never also accept a new request.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_handoff   = 1'b0;
        in_ready    = 1'b0;
        busy        = 1'b0;
        p4_a        = '0;
        p4_b        = '0;
        p4_cin      = 1'b0;
        out_valid   = 1'b0;
        out_sum     = '0;
        out_cout    = 1'b0;
        out_ovf     = 1'b0;

        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid) begin
                    w_nextState = RUN;
                end
            end

            RUN: begin
                busy   = 1'b1;
                p4_a   = r_aReg[r_idx];
                p4_b   = r_bReg[r_idx];
                // Word 0 takes the caller's carry-in; later words take the
                // carry-out registered from the previous word.
                p4_cin = (r_idx == '0) ? r_cinReg : r_carryReg;
                if (w_lastWord) begin
                    w_nextState = DONE;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                out_sum   = r_sumReg;
                out_cout  = r_carryReg;
                // Overflow: operands agree in sign but the sum's sign differs.
                out_ovf   = (r_aReg[NWORDS-1][DWIDTH-1] == r_bReg[NWORDS-1][DWIDTH-1]) &&
                            (r_sumReg[NWORDS-1][DWIDTH-1] != r_aReg[NWORDS-1][DWIDTH-1]);
                w_handoff = out_ready;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath registers. Operands are captured on acceptance; during RUN the
    // P4 result for the current word is stored and its carry kept for the next
    // word. The counter advances only on an actual downstream handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aReg     <= '0;
            r_bReg     <= '0;
            r_sumReg   <= '0;
            r_cinReg   <= 1'b0;
            r_carryReg <= 1'b0;
            r_idx      <= '0;
            r_opCount  <= '0;
        end else begin
            if (w_accept) begin
                r_aReg   <= in_a;
                r_bReg   <= in_b;
                r_cinReg <= in_cin;
                r_idx    <= '0;
            end

            if (r_state == RUN) begin
                r_sumReg[r_idx] <= p4_s;
                r_carryReg      <= p4_cout;
                if (!w_lastWord) begin
                    r_idx <= r_idx + IW'(1);
                end
            end

            if (w_handoff) begin
                r_opCount <= r_opCount + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_p4_wide_add_seq.sv
// ----------------------------------------------------------------------------
// tb_p4_wide_add_seq
//
// Purpose:
//     Self-checking bench for p4_wide_add_seq. A behavioural P4 adder sits
//     beside the DUT on the p4_* ports. Expected results are computed from the
//     wide operands when a request is driven, queued, and popped when the DUT
//     presents its result.
// ----------------------------------------------------------------------------
module tb_p4_wide_add_seq;

    localparam int DWIDTH = 32;
    localparam int NWORDS = 4;
    localparam int CNTW   = 16;
    localparam int W      = NWORDS * DWIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_a;
    logic [W-1:0]      in_b;
    logic              in_cin;
    logic [DWIDTH-1:0] p4_a;
    logic [DWIDTH-1:0] p4_b;
    logic              p4_cin;
    logic [DWIDTH-1:0] p4_s;
    logic              p4_cout;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_sum;
    logic              out_cout;
    logic              out_ovf;
    logic              busy;
    logic [CNTW-1:0]   op_count;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   expCount = 0;

    // Clock generation, 10 ns period.
    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational P4 adder.
    assign {p4_cout, p4_s} = {1'b0, p4_a} + {1'b0, p4_b} + {{DWIDTH{1'b0}}, p4_cin};

    p4_wide_add_seq #(
        .DWIDTH (DWIDTH),
        .NWORDS (NWORDS),
        .CNTW   (CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .p4_a      (p4_a),
        .p4_b      (p4_b),
        .p4_cin    (p4_cin),
        .p4_s      (p4_s),
        .p4_cout   (p4_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy),
        .op_count  (op_count)
    );

    // Reference model of the full-width add.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] full;
        exp_t       m;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        m.sum  = full[W-1:0];
        m.cout = full[W];
        m.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return m;
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, queue its expected result, return one step after
    // the accepting edge (DUT then in RUN with idx 0).
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, output bit timedOut);
        int n;
        n = 0;
        sb.push_back(model(a, b, cin));
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        timedOut = !in_ready;
        step();
        in_valid = 1'b0;
    endtask

    task automatic waitValid(input int budget, output bit timedOut, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < budget) begin
            step();
            cycles++;
        end
        timedOut = !out_valid;
    endtask

    task automatic handOff();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        expCount++;
    endtask

    function automatic logic [W-1:0] randWide();
        logic [W-1:0] v;
        for (int w = 0; w < NWORDS; w++) begin
            v[w*DWIDTH +: DWIDTH] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
        return v;
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: {in_ready,out_valid,busy} got %b expected 100", {in_ready, out_valid, busy});
        end
        checks++;
        if ({out_sum, out_cout, out_ovf} !== '0 || op_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_result: sum %h cout %b ovf %b count %0d expected all 0",
                     out_sum, out_cout, out_ovf, op_count);
        end
        checks++;
        if ({p4_a, p4_b, p4_cin} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_p4: a %h b %h cin %b expected 0", p4_a, p4_b, p4_cin);
        end
    endtask

    task automatic test_carry_chain();
        bit   to;
        int   cyc;
        exp_t e;
        applyStimulus(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0, to);
        checks++;
        if (to) begin
            errors++;
            $display("[TB] FAIL carry_accept: in_ready got 0 expected 1");
        end
        waitValid(20, to, cyc);
        checks++;
        if (to || cyc != NWORDS) begin
            errors++;
            $display("[TB] FAIL carry_latency: got %0d cycles expected %0d", cyc, NWORDS);
        end
        e = sb.pop_front();
        checks++;
        if (out_sum !== 128'h0000_0000_0000_0000_0000_0001_0000_0000 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL carry_result: got %h/%b/%b expected 00000000000000000000000100000000/0/0",
                     out_sum, out_cout, out_ovf);
        end
        checks++;
        if ({out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
            errors++;
            $display("[TB] FAIL carry_model: got %h/%b/%b expected %h/%b/%b",
                     out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
        end
        handOff();
    endtask

    task automatic test_all_ones();
        bit   to;
        int   cyc;
        int   cinOnes;
        int   runCycles;
        exp_t e;
        applyStimulus({W{1'b1}}, '0, 1'b1, to);
        cinOnes   = 0;
        runCycles = 0;
        while (busy && runCycles < 10) begin
            if (p4_cin === 1'b1) cinOnes++;
            runCycles++;
            step();
        end
        checks++;
        if (cinOnes != NWORDS || runCycles != NWORDS) begin
            errors++;
            $display("[TB] FAIL ones_p4cin: cin=1 words got %0d of %0d expected %0d of %0d",
                     cinOnes, runCycles, NWORDS, NWORDS);
        end
        waitValid(20, to, cyc);
        e = sb.pop_front();
        checks++;
        if (to || out_sum !== '0 || out_cout !== 1'b1 || out_ovf !== 1'b0 ||
            {out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
            errors++;
            $display("[TB] FAIL ones_result: got %h/%b/%b expected %h/1/0", out_sum, out_cout, out_ovf, {W{1'b0}});
        end
        handOff();
    endtask

    task automatic test_overflow();
        bit   to;
        int   cyc;
        exp_t e;
        applyStimulus({1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, to);
        waitValid(20, to, cyc);
        e = sb.pop_front();
        checks++;
        if (to || out_sum !== {1'b1, {(W-1){1'b0}}} || out_ovf !== 1'b1 || out_cout !== 1'b0 ||
            {out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
            errors++;
            $display("[TB] FAIL ovf_result: got %h/cout %b/ovf %b expected 80000000000000000000000000000000/0/1",
                     out_sum, out_cout, out_ovf);
        end
        handOff();
    endtask

    task automatic test_backpressure();
        bit   to;
        int   cyc;
        exp_t e;
        applyStimulus(randWide(), randWide(), 1'b1, to);
        waitValid(20, to, cyc);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || op_count !== CNTW'(expCount) ||
                {out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: valid %b ready %b count %0d sum %h expected 1 0 %0d %h",
                         i, out_valid, in_ready, op_count, out_sum, expCount, e.sum);
            end
            step();
        end
        handOff();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_count !== CNTW'(expCount)) begin
            errors++;
            $display("[TB] FAIL bp_release: ready %b valid %b count %0d expected 1 0 %0d",
                     in_ready, out_valid, op_count, expCount);
        end
    endtask

    task automatic test_reset_mid_run();
        bit   to;
        int   cyc;
        exp_t e;
        applyStimulus(randWide(), randWide(), 1'b0, to);
        step();
        step();
        checks++;
        if (busy !== 1'b1 || p4_a !== in_a[2*DWIDTH +: DWIDTH]) begin
            errors++;
            $display("[TB] FAIL rst_run_word2: busy %b p4_a %h expected 1 %h", busy, p4_a, in_a[2*DWIDTH +: DWIDTH]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sb.pop_back());
        expCount = 0;
        checks++;
        if ({in_ready, out_valid, busy, out_cout, out_ovf, p4_cin} !== 6'b100000 ||
            out_sum !== '0 || op_count !== '0 || p4_a !== '0 || p4_b !== '0) begin
            errors++;
            $display("[TB] FAIL rst_run_clear: ready %b valid %b busy %b sum %h count %0d p4_a %h expected idle zeros",
                     in_ready, out_valid, busy, out_sum, op_count, p4_a);
        end
        applyStimulus(128'd5, 128'd7, 1'b0, to);
        waitValid(20, to, cyc);
        e = sb.pop_front();
        checks++;
        if (to || out_sum !== 128'd12 || {out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
            errors++;
            $display("[TB] FAIL rst_run_fresh: got %h expected %h", out_sum, 128'd12);
        end
        handOff();
    endtask

    task automatic test_random();
        bit   to;
        bit   done;
        int   n;
        int   base;
        exp_t e;
        base = expCount;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(randWide(), randWide(), 1'($urandom_range(0, 1)), to);
            done = 1'b0;
            n    = 0;
            while (!done && n < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    e = sb.pop_front();
                    checks++;
                    if ({out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
                        errors++;
                        $display("[TB] FAIL rand_%0d: got %h/%b/%b expected %h/%b/%b",
                                 i, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
                    end
                    done = 1'b1;
                    expCount++;
                end
                step();
                n++;
            end
            out_ready = 1'b0;
            if (!done || to) begin
                checks++;
                errors++;
                $display("[TB] FAIL rand_timeout_%0d: no result within %0d cycles", i, n);
                if (!done) void'(sb.pop_front());
            end
        end
        checks++;
        if (op_count !== CNTW'(base + 1000) || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL rand_count: op_count %0d queue %0d expected %0d 0",
                     op_count, sb.size(), CNTW'(base + 1000));
        end
    endtask

    // Watchdog so a hung handshake still terminates the run.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_carry_chain();
        test_all_ones();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/p4_wide_add_seq.md
Name: p4_wide_add_seq

Overview:
- Multi-word adder sequencer that drives the DWIDTH-bit combinational P4 adder one word per cycle.
- Chains COUT back into CIN to add NWORDS*DWIDTH-bit operands.
- Sits on the P4 operand/result boundary: feeds the P4 operand inputs and consumes its sum and carry in the same cycle.
- Valid/ready handshakes on the upstream operand side and the downstream result side.

Parameters:
- DWIDTH, 32, P4 adder word width in bits.
- NWORDS, 4, number of DWIDTH words per operand (>=1).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept an operand request.
- in_a  in  NWORDS*DWIDTH  operand A; word 0 is the LSW.
- in_b  in  NWORDS*DWIDTH  operand B.
- in_cin  in  1  carry-in to word 0.
- p4_a  out  DWIDTH  A word to the P4 adder.
- p4_b  out  DWIDTH  B word to the P4 adder.
- p4_cin  out  1  carry-in to the P4 adder.
- p4_s  in  DWIDTH  combinational sum from the P4 adder.
- p4_cout  in  1  combinational carry-out from the P4 adder.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  NWORDS*DWIDTH  assembled sum.
- out_cout  out  1  final carry-out, from the MSW.
- out_ovf  out  1  two's-complement signed overflow of the full-width add.
- busy  out  1  high in RUN.
- op_count  out  CNTW  completed (handed-off) operations; wraps modulo 2^CNTW.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge), all outputs and state cleared:
  - state=IDLE, in_ready=1.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
  - busy=0, op_count=0, idx=0, carry_reg=0.
  - p4_a=0, p4_b=0, p4_cin=0.
- Reset during RUN or DONE abandons the operation; no result is emitted and op_count is not incremented.
- State machine states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_a, in_b and in_cin into a_reg, b_reg and cin_reg; set idx=0; go to RUN.
- RUN:
  - Combinationally drive p4_a=a_reg[idx], p4_b=b_reg[idx].
  - Combinationally drive p4_cin = (idx==0) ? cin_reg : carry_reg.
  - Each rising edge: sum_reg[idx]<=p4_s, carry_reg<=p4_cout.
  - If idx==NWORDS-1, go to DONE; else idx<=idx+1.
  - P4 is purely combinational: one word per cycle, no wait states.
- DONE:
  - out_valid=1; out_sum=sum_reg; out_cout=carry_reg.
  - out_ovf = (a_msb==b_msb) && (sum_msb!=a_msb), using bit NWORDS*DWIDTH-1 of each operand and of the sum.
  - Hold all result outputs stable while out_ready=0.
  - On out_ready=1: op_count<=op_count+1, go to IDLE.
- P4 drive outside RUN: p4_a, p4_b and p4_cin are driven 0 in IDLE and DONE.
- Handshakes:
  - in_ready is high only in IDLE. No new request is accepted in the cycle a result is handed off; the earliest next acceptance is the following cycle.
  - in_valid while not ready is ignored; upstream must hold the request.
- Latency: acceptance edge E gives out_valid=1 from edge E+NWORDS onward; the P4 adder sees NWORDS consecutive words.
- NWORDS=1: RUN lasts one cycle; the idx counter width is max(1,$clog2(NWORDS)).
- Arithmetic: full result = in_a + in_b + in_cin modulo 2^(NWORDS*DWIDTH); out_cout is bit NWORDS*DWIDTH of the exact sum.
- op_count wraps from 2^CNTW-1 to 0.

Decomposition:
- Shared package p4_seq_pkg holds:
  - state enum seq_state_e {IDLE, RUN, DONE}.
  - function idx_width(n) returning max(1,$clog2(n)).
- The P4 adder itself is instantiated beside this block at the top level, connected through the p4_a/p4_b/p4_cin/p4_s/p4_cout ports.
- No sub-module is needed; the word mux and word write-enable stay inline.

Test Plan:
- Carry chain: A=0x00000000_00000000_00000000_FFFFFFFF, B=1, cin=0 → out_sum=0x...0001_00000000, out_cout=0, out_ovf=0; out_valid first seen 4 cycles after acceptance.
- All ones: A=all ones, B=0, cin=1 → out_sum=0, out_cout=1, out_ovf=0; p4_cin=1 on all four words.
- Signed overflow: A=0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1, cin=0 → out_sum=0x80000000_0..0, out_ovf=1, out_cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and out_sum stable, in_ready=0, op_count unchanged; then out_ready=1 → op_count+1, in_ready=1 next cycle.
- Reset mid-RUN: assert rst at idx=2 → next cycle IDLE, all outputs 0, op_count=0; a fresh request (A=5, B=7) then yields out_sum=12.
- Random: 1000 random A/B/cin with random out_ready → out_sum/out_cout match the reference model (A+B+cin); op_count=1000 mod 2^16.
